// File: rtl/aes_round_ctrl.sv
// Control sequencer for an iterative one-round AES-128 datapath: FSM, round counter and Rcon.
// The datapath registers and the round logic are external; this block only drives their selects and enables.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       st_load,
  output logic [1:0] st_sel,
  output logic       key_load,
  output logic [0:0] key_sel,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [3:0] LAST_MID = 4'(NR - 1);

  logic [1:0] state;
  logic       handoff;
  logic       accept;

  // Handshakes: a block is taken when in_valid && in_ready at a rising edge, and the
  // ciphertext is released when out_valid && out_ready at a rising edge. A release and
  // a new accept may share an edge, so in_ready in HOLD follows out_ready combinationally.
  assign handoff   = (state == HOLD) && out_ready;
  assign in_ready  = (state == IDLE) || handoff;
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round <= 4'd0;
      rcon  <= 8'h00;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            state <= ROUND;
            round <= 4'd1;
            rcon  <= 8'h01;
          end else if (handoff) begin
            state <= IDLE;
            round <= 4'd0;
            rcon  <= 8'h00;
          end
        end
        ROUND: begin
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
          if (round == LAST_MID) state <= FINAL;
        end
        FINAL: state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  // Loads in IDLE/HOLD fire only on the accept edge; everything else decodes from state.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    st_load   = 1'b0;
    st_sel    = 2'd0;
    key_load  = 1'b0;
    key_sel   = 1'b0;
    case (state)
      IDLE: begin
        st_load  = accept;
        key_load = accept;
      end
      ROUND: begin
        busy     = 1'b1;
        st_load  = 1'b1;
        st_sel   = 2'd1;
        key_load = 1'b1;
        key_sel  = 1'b1;
      end
      FINAL: begin
        busy     = 1'b1;
        st_load  = 1'b1;
        st_sel   = 2'd2;
        key_load = 1'b1;
        key_sel  = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        st_load   = accept;
        key_load  = accept;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an AES-128 datapath model driven by the controller outputs,
// a per-cycle control trace scoreboard and a ciphertext scoreboard.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2, S_HOLD = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy, st_load, key_load;
  logic [3:0] round;
  logic [7:0] rcon;
  logic [1:0] st_sel, fsm_state;
  logic [0:0] key_sel;

  logic in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic in_ready2, out_valid2, busy2, st_load2, key_load2;
  logic [3:0] round2;
  logic [7:0] rcon2;
  logic [1:0] st_sel2, fsm_state2;
  logic [0:0] key_sel2;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .round(round),
    .rcon(rcon), .st_load(st_load), .st_sel(st_sel), .key_load(key_load),
    .key_sel(key_sel), .fsm_state(fsm_state)
  );

  aes_round_ctrl #(.NR(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .round(round2),
    .rcon(rcon2), .st_load(st_load2), .st_sel(st_sel2), .key_load(key_load2),
    .key_sel(key_sel2), .fsm_state(fsm_state2)
  );

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [21:0]  ctl_q[$];
  logic [127:0] exp_q[$];
  int           stall_q[$];

  logic [7:0] rc_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [21:0] act_w, act_w2;
  assign act_w  = {fsm_state, round, rcon, st_load, st_sel, key_load, key_sel, busy, in_ready, out_valid};
  assign act_w2 = {fsm_state2, round2, rcon2, st_load2, st_sel2, key_load2, key_sel2, busy2, in_ready2, out_valid2};

  function automatic logic [21:0] mk(input logic [1:0] s, input logic [3:0] r, input logic [7:0] rc,
                                     input logic stl, input logic [1:0] sts, input logic kl, input logic ks,
                                     input logic b, input logic ir, input logic ov);
    return {s, r, rc, stl, sts, kl, ks, b, ir, ov};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES-128 datapath model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(c*4 + r) -: 8] = sbox_t[gb(s, ((c + r) % 4)*4 + r)];
    return o;
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, c*4); a1 = gb(s, c*4 + 1); a2 = gb(s, c*4 + 2); a3 = gb(s, c*4 + 3);
      o[127 - 8*(c*4)     -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127 - 8*(c*4 + 1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127 - 8*(c*4 + 2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127 - 8*(c*4 + 3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] key_in = '0, pt_in = '0;
  logic [127:0] st_reg, key_reg;

  always @(posedge clk) begin
    if (key_load === 1'b1) key_reg <= key_sel[0] ? expand(key_reg, rcon) : key_in;
    if (st_load === 1'b1) begin
      case (st_sel)
        2'd0: st_reg <= pt_in ^ key_in;
        2'd1: st_reg <= mixcol(sub_shift(st_reg)) ^ expand(key_reg, rcon);
        2'd2: st_reg <= sub_shift(st_reg) ^ expand(key_reg, rcon);
        default: st_reg <= st_reg;
      endcase
    end
  end

  // ---------------- consumer: out_ready after a per-block stall ----------------
  int hcnt = 0, cur_stall = 0;
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (hcnt == 0) cur_stall = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      out_ready = (hcnt == cur_stall);
      hcnt = out_ready ? 0 : hcnt + 1;
    end else begin
      out_ready = 1'b0;
      hcnt = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctl_q.size() > 0) chk("ctl_trace", act_w, ctl_q.pop_front());
      else chk("idle", {busy, out_valid, in_ready}, 3'b001);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ct_spurious actual=out_valid=1 expected=out_valid=0 at %0t", $time);
        end else begin
          chk("ciphertext", st_reg, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct,
                      input int stall, input bit b2b);
    int n = 0;
    key_in = k; pt_in = p; in_valid = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready=0 expected=in_ready=1 at %0t", $time);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int r = 1; r < NR; r++)
      ctl_q.push_back(mk(S_ROUND, 4'(r), rc_tab[r], 1, 2'd1, 1, 1, 1, 0, 0));
    ctl_q.push_back(mk(S_FINAL, 4'(NR), rc_tab[NR], 1, 2'd2, 1, 1, 1, 0, 0));
    for (int h = 0; h <= stall; h++) begin
      if (h == stall)
        ctl_q.push_back(mk(S_HOLD, 4'(NR), rc_tab[NR], b2b, 2'd0, b2b, 0, 0, 1, 1));
      else
        ctl_q.push_back(mk(S_HOLD, 4'(NR), rc_tab[NR], 0, 2'd0, 0, 0, 0, 0, 1));
    end
    exp_q.push_back(ct);
    stall_q.push_back(stall);
  endtask

  task automatic drain();
    int n = 0;
    while ((ctl_q.size() > 0 || exp_q.size() > 0) && n < 400) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_ctl", 128'(ctl_q.size()), 128'd0);
    chk("drain_ct", 128'(exp_q.size()), 128'd0);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int n;
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    // reset state, observed while rst is still high
    repeat (2) @(posedge clk);
    #1;
    ctl_q.push_back(mk(S_IDLE, 4'd0, 8'h00, 0, 2'd0, 0, 0, 0, 1, 0));
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 C.1 vector, no backpressure
    send(K1, P1, C1, 0, 0);
    drain();

    // 20 cycles of backpressure
    send(K2, P2, C2, 20, 0);
    drain();

    // back-to-back: second block accepted in the handoff cycle
    send(K1, P1, C1, 0, 1);
    send(K2, P2, C2, 0, 0);
    drain();

    // reset in round 5, then a clean block
    send(K2, P2, C2, 0, 0);
    n = 0;
    while (round !== 4'd5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_round5", {4'd0, round}, 8'd5);
    rst = 1'b1;
    while (ctl_q.size() > 1) void'(ctl_q.pop_back());
    exp_q.delete();
    stall_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ctl_q.push_back(mk(S_IDLE, 4'd0, 8'h00, 0, 2'd0, 0, 0, 0, 1, 0));
    repeat (15) @(posedge clk);
    #1;
    send(K1, P1, C1, 0, 0);
    drain();

    // NR=2 instance: IDLE -> ROUND -> FINAL -> HOLD -> IDLE
    in_valid2 = 1'b1;
    @(negedge clk);
    chk("nr2_idle", act_w2, {mk(S_IDLE, 4'd0, 8'h00, 1, 2'd0, 1, 0, 0, 1, 0)});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("nr2_c1", act_w2, {mk(S_ROUND, 4'd1, 8'h01, 1, 2'd1, 1, 1, 1, 0, 0)});
    @(negedge clk);
    chk("nr2_c2", act_w2, {mk(S_FINAL, 4'd2, 8'h02, 1, 2'd2, 1, 1, 1, 0, 0)});
    @(negedge clk);
    chk("nr2_c3", act_w2, {mk(S_HOLD, 4'd2, 8'h02, 0, 2'd0, 0, 0, 0, 1, 1)});
    @(negedge clk);
    chk("nr2_c4", act_w2, {mk(S_IDLE, 4'd0, 8'h00, 0, 2'd0, 0, 0, 0, 1, 0)});

    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("end_ctl_q", 128'(ctl_q.size()), 128'd0);
    chk("end_exp_q", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
